// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    localparam int              PC_W          = 32;
    localparam logic [PC_W-1:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
    localparam int              DEF_PC_STEP   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_HALT
    } fs_state_e;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Next-PC selection and the pending-redirect register; a live redirect beats a
// pending one, which beats sequential stepping.
module fetch_redirect_sel
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_STEP = DEF_PC_STEP
) (
    input  logic            clk_i,
    input  logic            clr_n_i,
    input  logic            jmp_i,
    input  logic [PC_W-1:0] jmp_target_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            latch_i,
    input  logic            consume_i,
    output logic            redir_o,
    output logic [PC_W-1:0] redir_pc_o,
    output logic            pend_vld_o,
    output logic [PC_W-1:0] next_pc_o
);

    logic            pend_vld_q, pend_vld_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic [PC_W-1:0] now_tgt;

    always_comb begin
        now_tgt    = jmp_i ? jmp_target_i : br_target_i;
        redir_o    = jmp_i | br_taken_i;
        redir_pc_o = redir_o ? now_tgt : pend_pc_q;
        next_pc_o  = (redir_o || pend_vld_q) ? redir_pc_o : pc_i + PC_W'(PC_STEP);
        pend_vld_o = pend_vld_q;
    end

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
        if (consume_i) begin
            pend_vld_d = 1'b0;
        end else if (latch_i && redir_o) begin
            // a later redirect simply overwrites an earlier pending one
            pend_vld_d = 1'b1;
            pend_pc_d  = now_tgt;
        end
    end

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch FSM: request, present to decode, step or
// redirect the PC, and stop for good on the halt word.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter int              PC_STEP   = DEF_PC_STEP,
    parameter logic [PC_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            run,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [PC_W-1:0] pc_q,
    output logic            halted
);

    fs_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] instr_q, instr_d;
    logic            gap_q, gap_d;
    logic            redir, pend_vld, latch_en, consume;
    logic [PC_W-1:0] redir_pc, next_pc;

    fetch_redirect_sel #(.PC_STEP(PC_STEP)) u_sel (
        .clk_i        (clk),
        .clr_n_i      (clr_n),
        .jmp_i        (jmp),
        .jmp_target_i (jmp_target),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .pc_i         (pc_q),
        .latch_i      (latch_en),
        .consume_i    (consume),
        .redir_o      (redir),
        .redir_pc_o   (redir_pc),
        .pend_vld_o   (pend_vld),
        .next_pc_o    (next_pc)
    );

    assign imem_addr = pc_q;
    assign instr     = instr_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        gap_d       = 1'b0;
        latch_en    = 1'b0;
        consume     = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redir) pc_d = redir_pc;
                if (run)   state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (gap_q) begin
                    // no request outstanding in the gap cycle, so retarget directly
                    if (redir) pc_d = redir_pc;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        consume = 1'b1;
                        if (redir || pend_vld) begin
                            pc_d  = redir_pc;
                            gap_d = 1'b1;
                        end else begin
                            instr_d = imem_rdata;
                            state_d = ST_PRESENT;
                        end
                    end else begin
                        latch_en = 1'b1;
                    end
                end
            end
            ST_PRESENT: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (instr_q == HALT_WORD) begin
                        state_d = ST_HALT;
                    end else begin
                        consume = 1'b1;
                        pc_d    = next_pc;
                        state_d = run ? ST_FETCH : ST_IDLE;
                    end
                end else begin
                    latch_en = 1'b1;
                end
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VEC;
            instr_q <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then randomized traffic, checked
// against an instruction-stream model of which PC must be presented next.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n, run, br_taken, jmp, imem_ack, instr_ready;
    logic [31:0] br_target, jmp_target, imem_rdata;
    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, instr, pc_q;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_VEC(32'h0), .PC_STEP(4), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk(clk), .clr_n(clr_n), .run(run), .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_q(pc_q), .halted(halted)
    );

    int          checks = 0, errors = 0;
    bit          halt_en = 1'b0;
    logic [31:0] halt_addr = 32'h0;
    int          ack_wait = 1, age = 0;
    logic [31:0] addrs[$];

    // model: PC expected at the next presentation, plus phase bookkeeping
    logic [31:0] m_pc, m_pend_pc;
    bit          m_pend, m_pres, m_halted, m_stale, m_idle, m_exp_req;
    int          m_gap;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_pend_pc = 32'h0; m_pend = 0; m_pres = 0; m_halted = 0;
        m_stale = 0; m_idle = 1; m_exp_req = 0; m_gap = 0; age = 0;
    endtask

    task automatic check_outputs();
        chk("halted", halted, m_halted);
        chk("instr_valid", instr_valid, m_pres);
        if (!m_stale) chk("pc_q", pc_q, m_pc);
        if (m_pres) chk("instr", instr, mem(m_pc));
        if (m_pres || m_halted || m_idle) chk("no_req", imem_req, 0);
        if (m_gap == 2) chk("gap_low", imem_req, 0);
        else if (m_gap == 1) chk("gap_req", imem_req, 1);
        if (m_exp_req) chk("req_next", imem_req, 1);
        if (imem_req && !m_stale) chk("imem_addr", imem_addr, m_pc);
        if (m_gap > 0) m_gap--;
        m_exp_req = 0;
    endtask

    // one clock: memory responds, model advances, outputs checked at negedge
    task automatic cyc();
        logic        red;
        logic [31:0] tgt;
        if (imem_req && age >= ack_wait) begin
            imem_ack = 1'b1; imem_rdata = mem(imem_addr); age = 0;
            addrs.push_back(imem_addr);
        end else begin
            imem_ack = 1'b0; imem_rdata = $urandom;
            age = imem_req ? age + 1 : 0;
        end
        red = jmp | br_taken;
        tgt = jmp ? jmp_target : br_target;
        if (!m_halted) begin
            if (m_pres) begin
                if (instr_ready) begin
                    m_pres = 0;
                    if (mem(m_pc) == 32'hFFFF_FFFF) m_halted = 1;
                    else begin
                        m_pc   = red ? tgt : (m_pend ? m_pend_pc : m_pc + 32'd4);
                        m_pend = 0;
                        if (run) m_exp_req = 1; else m_idle = 1;
                    end
                end else if (red) begin
                    m_pend = 1; m_pend_pc = tgt;
                end
            end else begin
                if (m_idle && run) begin m_idle = 0; m_exp_req = 1; end
                if (imem_req && imem_ack) begin
                    if (m_stale || red) m_gap = 2; else m_pres = 1;
                    m_stale = 0;
                end else if (imem_req && red) m_stale = 1;
                if (red) m_pc = tgt;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        #1;
        chk("rst_pc", pc_q, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_halted", halted, 0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n = 1'b1; run = 0; br_taken = 0; jmp = 0; br_target = 0; jmp_target = 0;
        imem_ack = 0; imem_rdata = 0; instr_ready = 0;
        #1;
        do_reset();

        // sequential fetch from reset
        run = 1; instr_ready = 1; ack_wait = 1; addrs.delete();
        repeat (20) cyc();
        chk("seq_len", addrs.size() >= 4, 1);
        if (addrs.size() >= 4)
            for (int i = 0; i < 4; i++) chk("seq_addr", addrs[i], 32'(i * 4));

        // jmp beats br in the same cycle
        run = 0; repeat (10) cyc();
        jmp = 1; jmp_target = 32'h100; br_taken = 1; br_target = 32'h200;
        cyc();
        jmp = 0; br_taken = 0; run = 1; addrs.delete();
        repeat (6) cyc();
        chk("jmp_pri", addrs.size() > 0 ? addrs[0] : 32'hX, 32'h100);

        // branch during a slow fetch discards the returned word
        ack_wait = 3;
        begin
            int n = 0;
            while (!(imem_req && age == 0 && !m_stale) && n < 20) begin cyc(); n++; end
            chk("br_sync", n < 20, 1);
        end
        br_taken = 1; br_target = 32'h340;
        cyc();
        br_taken = 0; addrs.delete();
        begin
            int n = 0;
            while (!instr_valid && n < 20) begin cyc(); n++; end
            chk("br_wait", n < 20, 1);
        end
        chk("br_pc", pc_q, 32'h340);
        chk("br_instr", instr, mem(32'h340));
        chk("br_refetch", addrs.size() > 0 ? addrs[addrs.size()-1] : 32'hX, 32'h340);

        // decode stall holds the presented instruction
        ack_wait = 1;
        begin
            int n = 0;
            instr_ready = 0;
            while (!m_pres && n < 20) begin cyc(); n++; end
            chk("stall_wait", n < 20, 1);
        end
        repeat (5) cyc();
        chk("stall_valid", instr_valid, 1);
        instr_ready = 1;

        // PC wraps past the top of the address space
        run = 0; repeat (10) cyc();
        jmp = 1; jmp_target = 32'hFFFF_FFFC;
        cyc();
        jmp = 0; run = 1; addrs.delete();
        repeat (12) cyc();
        chk("wrap", addrs.size() > 1 ? addrs[1] : 32'hX, 32'h0);

        // halt word at pc 8
        do_reset();
        halt_en = 1; halt_addr = 32'h8; run = 1; instr_ready = 1; ack_wait = 1;
        repeat (25) cyc();
        chk("halt_flag", halted, 1);
        chk("halt_pc", pc_q, 32'h8);
        chk("halt_req", imem_req, 0);

        // reset mid-fetch at the top address
        do_reset();
        halt_en = 0; run = 0;
        jmp = 1; jmp_target = 32'hFFFF_FFFC;
        cyc();
        jmp = 0; run = 1; ack_wait = 20;
        repeat (3) cyc();
        chk("pre_rst_req", imem_req, 1);
        chk("pre_rst_pc", pc_q, 32'hFFFF_FFFC);
        #2;
        do_reset();

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            run         = ($urandom % 8) != 0;
            instr_ready = ($urandom % 3) != 0;
            jmp         = ($urandom % 16) == 0;
            br_taken    = ($urandom % 12) == 0;
            jmp_target  = $urandom & 32'hFFFF_FFFC;
            br_target   = $urandom & 32'hFFFF_FFFC;
            ack_wait    = $urandom_range(0, 3);
            if ($urandom % 500 == 0) begin
                #2;
                do_reset();
            end else begin
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, sequential PC increment in bytes.
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction word that halts fetch.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 clr_n  in  1  asynchronous active-low reset.
REQ-007 run  in  1  level enable; fetch proceeds while high.
REQ-008 br_taken  in  1  branch redirect pulse.
REQ-009 br_target  in  32  branch destination address.
REQ-010 jmp  in  1  jump redirect pulse.
REQ-011 jmp_target  in  32  jump destination address.
REQ-012 imem_req  out  1  instruction memory request, held until acknowledged.
REQ-013 imem_addr  out  32  fetch address; equals pc_q while imem_req is high.
REQ-014 imem_ack  in  1  memory acknowledge; imem_rdata valid in the same cycle.
REQ-015 imem_rdata  in  32  fetched word.
REQ-016 instr  out  32  registered instruction to decode.
REQ-017 instr_valid  out  1  instr holds a valid instruction.
REQ-018 instr_ready  in  1  decode accepts instr.
REQ-019 pc_q  out  32  address of the instruction in flight or presented.
REQ-020 halted  out  1  high in HALT state.

Function
REQ-021 FSM states IDLE, FETCH, PRESENT, HALT; one-hot or binary is implementation's choice.
REQ-022 IDLE: imem_req=0, instr_valid=0; run=1 -> FETCH next cycle.
REQ-023 FETCH: imem_req=1; imem_ack=1 with no pending redirect -> instr<=imem_rdata, PRESENT.
REQ-024 PRESENT: instr_valid=1; instr and pc_q stable until instr_valid&&instr_ready.
REQ-025 Handshake in PRESENT: if instr==HALT_WORD -> HALT, pc_q unchanged; else pc_q<=next PC, then FETCH if run=1, IDLE if run=0.
REQ-026 Next PC = jmp_target if jmp, else br_target if br_taken, else pc_q+PC_STEP; jmp has priority when both assert.
REQ-027 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
REQ-028 Redirect in FETCH: target latched into pending register; current request completes; on imem_ack data is discarded, pc_q<=pending target, remain FETCH (new request next cycle, imem_req low for exactly one cycle).
REQ-029 Redirect coincident with imem_ack in FETCH: treated per REQ-028 (data discarded).
REQ-030 Redirect in PRESENT without handshake: latched pending; applied as next PC at handshake, overriding PC_STEP; instr still delivered.
REQ-031 Second redirect while one is pending: the later one overwrites the pending target.
REQ-032 Redirect in IDLE: pc_q<=target immediately; stays IDLE until run=1.
REQ-033 run deassert in FETCH: outstanding request completes; after ack go PRESENT as normal.
REQ-034 HALT: imem_req=0, instr_valid=0, halted=1; exits only via reset.
REQ-035 Fetch latency: imem_ack in cycle N -> instr_valid high in cycle N+1.

Reset
REQ-036 clr_n low asynchronously forces IDLE, pc_q=RESET_VEC, instr=0, instr_valid=0, imem_req=0, halted=0, pending redirect cleared.
REQ-037 Reset mid-request abandons it; any imem_ack during or after reset before next request is ignored.
REQ-038 Release of clr_n is synchronized externally; no internal synchronizer.

Structure
REQ-039 Shared package holds the FSM state enum, PC width constant (32), default RESET_VEC and HALT_WORD.
REQ-040 One sub-module: fetch_redirect_sel, combinational next-PC mux plus pending-redirect register.

Verification
REQ-041 Reset then run=1, imem_ack one cycle after each req, instr_ready=1 -> imem_addr sequence 0,4,8,12.
REQ-042 jmp=1, jmp_target=32'h100 with br_taken=1, br_target=32'h200 in same cycle -> next imem_addr 32'h100.
REQ-043 br_taken in FETCH, ack delayed 3 cycles -> returned word not presented; next imem_addr = br_target.
REQ-044 instr_ready held low 5 cycles in PRESENT -> instr, pc_q, instr_valid stable; no imem_req.
REQ-045 Fetch returns 32'hFFFF_FFFF at pc 8 -> accepted, halted=1, imem_req stays 0 with run=1.
REQ-046 clr_n low mid-FETCH at pc 32'hFFFF_FFFC -> pc_q=0, all outputs at reset values immediately.
